// File: rtl/hazard3_clint_mh.sv
// rtl/hazard3_clint_mh.sv - APB timer/software interrupt block with a small external-interrupt gateway
module hazard3_clint_mh #(
  parameter int N_HARTS   = 2,
  parameter int NIRQ      = 8,
  parameter int TICKDIV_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               dbg_halt,
  input  logic               tick,
  input  logic [NIRQ-1:0]    irq,
  output logic [N_HARTS-1:0] soft_irq,
  output logic [N_HARTS-1:0] timer_irq,
  output logic               ext_irq
);

  localparam logic [TICKDIV_W-1:0] PRESC_ONE = 1;

  logic                 r_pready;
  logic [63:0]          r_mtime;
  logic [TICKDIV_W-1:0] r_presc;
  logic [TICKDIV_W-1:0] r_tickdiv;
  logic [N_HARTS-1:0]   r_msip;
  logic [N_HARTS-1:0]   r_timer_irq;
  logic [63:0]          r_mtimecmp [N_HARTS];
  logic [NIRQ-1:0]      r_enable;
  logic [NIRQ-1:0]      r_pending;
  logic [NIRQ-1:0]      r_inservice;
  logic                 r_ext_irq;

  logic                 w_access;
  logic                 w_commit;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_hit;
  logic [31:0]          w_rdata;
  logic [N_HARTS-1:0]   w_msip_sel;
  logic [N_HARTS-1:0]   w_cmp_lo_sel;
  logic [N_HARTS-1:0]   w_cmp_hi_sel;
  logic                 w_mtime_lo_sel;
  logic                 w_mtime_hi_sel;
  logic                 w_tickdiv_sel;
  logic                 w_claim_sel;
  logic                 w_enable_sel;
  logic [NIRQ-1:0]      w_pe;
  logic [NIRQ-1:0]      w_claim_oh;
  logic [31:0]          w_claim_id;
  logic                 w_found;
  logic                 w_tick_en;
  logic                 w_presc_wrap;
  logic                 w_mtime_inc;

  // The access cycle with pready high is the only one that commits side effects
  assign w_access = psel & penable;
  assign w_commit = w_access & r_pready;
  assign w_wr     = w_commit & pwrite;
  assign w_rd     = w_commit & ~pwrite;

  assign w_pe = r_pending & r_enable;

  // Lowest-numbered enabled pending source wins the claim
  always_comb begin
    w_claim_oh = '0;
    w_claim_id = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NIRQ; i++) begin
      if (!w_found && w_pe[i]) begin
        w_found       = 1'b1;
        w_claim_oh[i] = 1'b1;
        w_claim_id    = 32'(i + 1);
      end
    end
  end

  // Address decode and read mux; anything not matched is an error
  always_comb begin
    w_hit          = 1'b0;
    w_rdata        = '0;
    w_msip_sel     = '0;
    w_cmp_lo_sel   = '0;
    w_cmp_hi_sel   = '0;
    w_mtime_lo_sel = 1'b0;
    w_mtime_hi_sel = 1'b0;
    w_tickdiv_sel  = 1'b0;
    w_claim_sel    = 1'b0;
    w_enable_sel   = 1'b0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (paddr == 16'(4 * h)) begin
        w_msip_sel[h] = 1'b1;
        w_hit         = 1'b1;
        w_rdata       = {31'd0, r_msip[h]};
      end
      if (paddr == 16'(32'h4100 + 8 * h)) begin
        w_cmp_lo_sel[h] = 1'b1;
        w_hit           = 1'b1;
        w_rdata         = r_mtimecmp[h][31:0];
      end
      if (paddr == 16'(32'h4104 + 8 * h)) begin
        w_cmp_hi_sel[h] = 1'b1;
        w_hit           = 1'b1;
        w_rdata         = r_mtimecmp[h][63:32];
      end
    end
    case (paddr)
      16'h4000: begin w_mtime_lo_sel = 1'b1; w_hit = 1'b1; w_rdata = r_mtime[31:0];    end
      16'h4004: begin w_mtime_hi_sel = 1'b1; w_hit = 1'b1; w_rdata = r_mtime[63:32];   end
      16'h4008: begin w_tickdiv_sel  = 1'b1; w_hit = 1'b1; w_rdata = 32'(r_tickdiv);   end
      16'h8000: begin w_claim_sel    = 1'b1; w_hit = 1'b1; w_rdata = w_claim_id;       end
      16'h8004: begin w_enable_sel   = 1'b1; w_hit = 1'b1; w_rdata = 32'(r_enable);    end
      default: ;
    endcase
  end

  assign pready    = r_pready;
  assign prdata    = (w_commit && w_hit) ? w_rdata : 32'd0;
  assign pslverr   = w_commit & ~w_hit;
  assign soft_irq  = r_msip;
  assign timer_irq = r_timer_irq;
  assign ext_irq   = r_ext_irq;

  // One wait state: pready rises on the second access cycle and drops after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pready <= 1'b0;
    else        r_pready <= w_access & ~r_pready;
  end

  assign w_tick_en    = tick & ~dbg_halt;
  assign w_presc_wrap = (r_presc == r_tickdiv);
  assign w_mtime_inc  = w_tick_en & w_presc_wrap;

  // Prescaler and 64-bit mtime; a bus write to either half wins over the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_tickdiv <= '0;
      r_mtime   <= '0;
    end else begin
      if (w_tick_en) r_presc <= w_presc_wrap ? '0 : r_presc + PRESC_ONE;
      if (w_wr && w_tickdiv_sel) r_tickdiv <= pwdata[TICKDIV_W-1:0];
      if (w_wr && w_mtime_lo_sel)      r_mtime[31:0]  <= pwdata;
      else if (w_wr && w_mtime_hi_sel) r_mtime[63:32] <= pwdata;
      else if (w_mtime_inc)            r_mtime        <= r_mtime + 64'd1;
    end
  end

  // Per-hart msip, mtimecmp and the registered unsigned timer compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msip      <= '0;
      r_timer_irq <= '0;
      for (int h = 0; h < N_HARTS; h++) r_mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (w_wr && w_msip_sel[h])   r_msip[h]              <= pwdata[0];
        if (w_wr && w_cmp_lo_sel[h]) r_mtimecmp[h][31:0]    <= pwdata;
        if (w_wr && w_cmp_hi_sel[h]) r_mtimecmp[h][63:32]   <= pwdata;
        r_timer_irq[h] <= (r_mtime >= r_mtimecmp[h]);
      end
    end
  end

  // Gateways: claim moves pending to inservice; complete reopens, irq re-pends a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable    <= '0;
      r_pending   <= '0;
      r_inservice <= '0;
      r_ext_irq   <= 1'b0;
    end else begin
      r_ext_irq <= |w_pe;
      if (w_wr && w_enable_sel) r_enable <= pwdata[NIRQ-1:0];
      for (int i = 0; i < NIRQ; i++) begin
        if (w_rd && w_claim_sel && w_claim_oh[i]) begin
          r_pending[i]   <= 1'b0;
          r_inservice[i] <= 1'b1;
        end else if (irq[i] && !r_pending[i] && !r_inservice[i]) begin
          r_pending[i] <= 1'b1;
        end
        if (w_wr && w_claim_sel && (pwdata == 32'(i + 1))) r_inservice[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard3_clint_mh.sv
// tb/tb_hazard3_clint_mh.sv - randomized bench for hazard3_clint_mh against a behavioural model
module tb_hazard3_clint_mh;
  localparam int NH = 2;
  localparam int NI = 8;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic [31:0]   prdata;
  logic          pready;
  logic          pslverr;
  logic          dbg_halt = 1'b0;
  logic          tick = 1'b0;
  logic [NI-1:0] irq = '0;
  logic [NH-1:0] soft_irq;
  logic [NH-1:0] timer_irq;
  logic          ext_irq;

  always #5 clk = ~clk;

  hazard3_clint_mh #(.N_HARTS(NH), .NIRQ(NI), .TICKDIV_W(TW)) u_dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .dbg_halt(dbg_halt), .tick(tick), .irq(irq),
    .soft_irq(soft_irq), .timer_irq(timer_irq), .ext_irq(ext_irq)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [63:0]   m_mtime;
  logic [TW-1:0] m_presc;
  logic [TW-1:0] m_tickdiv;
  logic [NH-1:0] m_msip;
  logic [NH-1:0] m_timer;
  logic [63:0]   m_cmp [NH];
  logic [NI-1:0] m_en;
  logic [NI-1:0] m_pend;
  logic [NI-1:0] m_insvc;
  logic          m_ext;
  logic          c_valid = 1'b0;
  logic          c_write = 1'b0;
  logic [15:0]   c_addr = '0;
  logic [31:0]   c_data = '0;
  bit            rnd_in = 1'b0;
  logic [15:0]   addrs [16];

  task automatic m_reset();
    m_mtime = '0; m_presc = '0; m_tickdiv = '0; m_msip = '0; m_timer = '0;
    m_en = '0; m_pend = '0; m_insvc = '0; m_ext = 1'b0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
  endtask

  function automatic int m_claim_id();
    for (int i = 0; i < NI; i++) if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  // kinds: 0 error, 1 msip, 2 mtime lo, 3 mtime hi, 4 tickdiv, 5 cmp lo, 6 cmp hi, 7 claim, 8 enable
  function automatic void m_decode(input logic [15:0] a, output int kind, output int idx);
    kind = 0; idx = 0;
    if (a[1:0] != 2'b00) kind = 0;
    else if (a < 16'h4000) begin
      idx = int'(a) / 4;
      if (idx < NH) kind = 1;
    end
    else if (a == 16'h4000) kind = 2;
    else if (a == 16'h4004) kind = 3;
    else if (a == 16'h4008) kind = 4;
    else if (a >= 16'h4100 && a < 16'h4200) begin
      idx = (int'(a) - 'h4100) / 8;
      if (idx < NH) kind = a[2] ? 6 : 5;
    end
    else if (a == 16'h8000) kind = 7;
    else if (a == 16'h8004) kind = 8;
  endfunction

  function automatic void m_read(input logic [15:0] a, output logic [31:0] d, output logic e);
    int kind, idx;
    m_decode(a, kind, idx);
    e = (kind == 0);
    d = '0;
    case (kind)
      1: d = {31'd0, m_msip[idx]};
      2: d = m_mtime[31:0];
      3: d = m_mtime[63:32];
      4: d = 32'(m_tickdiv);
      5: d = m_cmp[idx][31:0];
      6: d = m_cmp[idx][63:32];
      7: d = 32'(m_claim_id());
      8: d = 32'(m_en);
      default: d = '0;
    endcase
  endfunction

  // one rising edge of the model, everything derived from the pre-edge state
  task automatic m_edge();
    logic [NH-1:0] t_n;
    logic          e_n;
    logic [NI-1:0] set_p;
    logic          inc;
    int            kind, idx, cid;
    for (int h = 0; h < NH; h++) t_n[h] = (m_mtime >= m_cmp[h]);
    e_n   = |(m_pend & m_en);
    set_p = irq & ~m_pend & ~m_insvc;
    inc   = 1'b0;
    if (tick && !dbg_halt) begin
      if (m_presc == m_tickdiv) begin m_presc = '0; inc = 1'b1; end
      else m_presc = m_presc + 1'b1;
    end
    cid = 0;
    if (c_valid) begin
      m_decode(c_addr, kind, idx);
      if (!c_write && kind == 7) cid = m_claim_id();
      if (c_write) begin
        case (kind)
          1: m_msip[idx] = c_data[0];
          2: begin m_mtime[31:0] = c_data; inc = 1'b0; end
          3: begin m_mtime[63:32] = c_data; inc = 1'b0; end
          4: m_tickdiv = c_data[TW-1:0];
          5: m_cmp[idx][31:0] = c_data;
          6: m_cmp[idx][63:32] = c_data;
          7: for (int i = 0; i < NI; i++) if (c_data == 32'(i + 1)) m_insvc[i] = 1'b0;
          8: m_en = c_data[NI-1:0];
          default: ;
        endcase
      end
    end
    if (cid != 0) begin
      m_pend[cid-1]  = 1'b0;
      m_insvc[cid-1] = 1'b1;
    end
    m_pend = m_pend | set_p;
    if (inc) m_mtime = m_mtime + 64'd1;
    m_timer = t_n;
    m_ext   = e_n;
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    m_edge();
    #1;
    chk("soft_irq", 64'(soft_irq), 64'(m_msip));
    chk("timer_irq", 64'(timer_irq), 64'(m_timer));
    chk("ext_irq", 64'(ext_irq), 64'(m_ext));
    if (rnd_in) begin
      tick     = 1'($urandom_range(0, 1));
      dbg_halt = ($urandom_range(0, 7) == 0);
      irq      = NI'($urandom);
    end
  endtask

  task automatic apb(input logic wr, input logic [15:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    logic [31:0] ed;
    logic        ee;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    chk("pready_setup", 64'(pready), 64'd0);
    clk_cycle();
    penable = 1'b1;
    @(negedge clk);
    chk("pready_wait", 64'(pready), 64'd0);
    clk_cycle();
    @(negedge clk);
    chk("pready_ack", 64'(pready), 64'd1);
    m_read(a, ed, ee);
    rd  = prdata;
    err = pslverr;
    chk("pslverr", 64'(err), 64'(ee));
    if (!wr) chk("prdata", 64'(rd), 64'(ed));
    c_valid = 1'b1; c_write = wr; c_addr = a; c_data = d;
    clk_cycle();
    c_valid = 1'b0;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("pready_idle", 64'(pready), 64'd0);
    clk_cycle();
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        err;
    apb(1'b1, a, d, rd, err);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] rd);
    logic err;
    apb(1'b0, a, 32'd0, rd, err);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [15:0] a;
    logic [31:0] d;
    addrs = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008, 16'h4100, 16'h4104,
              16'h4108, 16'h410C, 16'h4110, 16'h8000, 16'h8000, 16'h8004, 16'h1234, 16'h4002};
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_pslverr", 64'(pslverr), 64'd0);
    chk("rst_soft", 64'(soft_irq), 64'd0);
    chk("rst_timer", 64'(timer_irq), 64'd0);
    chk("rst_ext", 64'(ext_irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clk_cycle();
    bus_rd(16'h4100, rd); chk("rst_cmp0_lo", 64'(rd), 64'hFFFF_FFFF);
    bus_rd(16'h410C, rd); chk("rst_cmp1_hi", 64'(rd), 64'hFFFF_FFFF);
    bus_rd(16'h4000, rd); chk("rst_mtime", 64'(rd), 64'd0);

    // prescaler divide-by-4 and debug halt
    bus_wr(16'h4008, 32'd3);
    tick = 1'b1; repeat (8) clk_cycle(); tick = 1'b0;
    bus_rd(16'h4000, rd); chk("div_mtime", 64'(rd), 64'd2);
    dbg_halt = 1'b1; tick = 1'b1; repeat (6) clk_cycle(); tick = 1'b0; dbg_halt = 1'b0;
    bus_rd(16'h4000, rd); chk("halt_mtime", 64'(rd), 64'd2);
    tick = 1'b1; repeat (3) clk_cycle(); tick = 1'b0;
    bus_rd(16'h4000, rd); chk("halt_presc_a", 64'(rd), 64'd2);
    tick = 1'b1; clk_cycle(); tick = 1'b0;
    bus_rd(16'h4000, rd); chk("halt_presc_b", 64'(rd), 64'd3);

    // timer compare on hart 1
    bus_wr(16'h4008, 32'd0);
    bus_wr(16'h410C, 32'd0);
    bus_wr(16'h4108, 32'd5);
    bus_wr(16'h4004, 32'd0);
    bus_wr(16'h4000, 32'd4);
    chk("cmp_below", 64'(timer_irq), 64'd0);
    tick = 1'b1; clk_cycle(); tick = 1'b0;
    chk("cmp_lag", 64'(timer_irq), 64'd0);
    clk_cycle();
    chk("cmp_hit", 64'(timer_irq), 64'b10);

    // mtime wraps to zero
    bus_wr(16'h4000, 32'hFFFF_FFFF);
    bus_wr(16'h4004, 32'hFFFF_FFFF);
    chk("wrap_max", 64'(timer_irq), 64'b11);
    tick = 1'b1; clk_cycle(); tick = 1'b0;
    clk_cycle();
    chk("wrap_clear", 64'(timer_irq), 64'd0);
    bus_rd(16'h4000, rd); chk("wrap_lo", 64'(rd), 64'd0);
    bus_rd(16'h4004, rd); chk("wrap_hi", 64'(rd), 64'd0);

    // claim / complete sequence
    bus_wr(16'h8004, 32'h6);
    irq = 8'h06;
    repeat (2) clk_cycle();
    chk("ext_on", 64'(ext_irq), 64'd1);
    bus_rd(16'h8000, rd); chk("claim_a", 64'(rd), 64'd2);
    bus_rd(16'h8000, rd); chk("claim_b", 64'(rd), 64'd3);
    bus_rd(16'h8000, rd); chk("claim_none", 64'(rd), 64'd0);
    chk("ext_off", 64'(ext_irq), 64'd0);
    bus_wr(16'h8000, 32'd9);
    bus_wr(16'h8000, 32'd0);
    bus_rd(16'h8000, rd); chk("claim_bad_id", 64'(rd), 64'd0);
    bus_wr(16'h8000, 32'd2);
    bus_rd(16'h8000, rd); chk("claim_again", 64'(rd), 64'd2);
    irq = '0;
    bus_wr(16'h8000, 32'd2);
    bus_wr(16'h8000, 32'd3);

    // error response and msip
    apb(1'b0, 16'h0008, 32'd0, rd, err);
    chk("err_flag", 64'(err), 64'd1);
    chk("err_data", 64'(rd), 64'd0);
    bus_wr(16'h0004, 32'd1);
    chk("msip1", 64'(soft_irq), 64'b10);

    // abandoned transfer leaves no trace
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'd1;
    clk_cycle();
    penable = 1'b1;
    clk_cycle();
    psel = 1'b0; penable = 1'b0;
    repeat (2) clk_cycle();
    bus_rd(16'h0000, rd); chk("abandon", 64'(rd), 64'd0);

    // randomized traffic
    rnd_in = 1'b1;
    for (int n = 0; n < 200; n++) begin
      a = addrs[$urandom_range(0, 15)];
      case (a)
        16'h4000, 16'h4100, 16'h4108: d = $urandom_range(0, 60);
        16'h4004, 16'h4104, 16'h410C: d = ($urandom_range(0, 7) == 0) ? $urandom : 32'd0;
        16'h4008: d = $urandom_range(0, 3);
        16'h8000: d = $urandom_range(0, NI + 1);
        default:  d = $urandom;
      endcase
      apb(1'($urandom_range(0, 1)), a, d, rd, err);
      repeat ($urandom_range(0, 2)) clk_cycle();
    end
    rnd_in = 1'b0; tick = 1'b0; dbg_halt = 1'b0; irq = '0;
    clk_cycle();

    // reset during the acknowledge cycle aborts the write
    bus_wr(16'h4000, 32'd0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'd1;
    clk_cycle();
    penable = 1'b1;
    clk_cycle();
    rst_n = 1'b0;
    m_reset();
    #1;
    psel = 1'b0; penable = 1'b0;
    chk("arst_pready", 64'(pready), 64'd0);
    chk("arst_soft", 64'(soft_irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clk_cycle();
    bus_rd(16'h0000, rd); chk("arst_msip0", 64'(rd), 64'd0);
    bus_rd(16'h4104, rd); chk("arst_cmp0_hi", 64'(rd), 64'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
